// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, receiver state encoding and baud divisor helper.
package uart_pkg;

    localparam int data_bits = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    // Whole clock cycles per serial bit; the remainder shows up as baud error.
    function automatic int calc_clks_per_bit(input int f_clk, input int baud);
        return f_clk / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side handshake and status bundle of the UART receiver.
interface uart_rx_if;
    import uart_pkg::*;

    logic [data_bits-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, busy,
        output rx_ready
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 1 (line idle).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized line, byte handed out
// on a valid/ready register with framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clk_hz    = 50_000_000,
    parameter int baud_rate = 115_200
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rxd,
    uart_rx_if.master rx_if
);
    localparam int CLKS_PER_BIT = calc_clks_per_bit(clk_hz, baud_rate);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TMR_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(data_bits);

    localparam logic [TMR_W-1:0] FULL_TC  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] HALF_TC  = TMR_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(data_bits - 1);

    localparam logic [2:0] S_IDLE      = IDLE;
    localparam logic [2:0] S_START     = START;
    localparam logic [2:0] S_DATA      = DATA;
    localparam logic [2:0] S_STOP      = STOP;
    localparam logic [2:0] S_WAIT_IDLE = WAIT_IDLE;

    logic                 rxd_s;
    logic [2:0]           state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [data_bits-1:0] shift_q, shift_d;
    logic [data_bits-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 tick_full, tick_half;
    logic                 byte_done;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    assign tick_full = (timer_q == FULL_TC);
    assign tick_half = (timer_q == HALF_TC);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        byte_done   = 1'b0;

        if (rx_valid_q && rx_if.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_d = S_START;
                    timer_d = '0;
                end
            end
            S_START: begin
                if (tick_half) begin
                    timer_d = '0;
                    // A start bit that is high again at its midpoint was a glitch.
                    if (!rxd_s) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tick_full) begin
                    timer_d          = '0;
                    shift_d[bit_idx_q] = rxd_s;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tick_full) begin
                    timer_d = '0;
                    // Leaving at mid-stop leaves half a bit to catch the next start edge.
                    if (rxd_s) begin
                        state_d   = S_IDLE;
                        byte_done = 1'b1;
                    end else begin
                        state_d     = S_WAIT_IDLE;
                        frame_err_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (rxd_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (byte_done) begin
            if (!rx_valid_q || rx_if.rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;
    assign rx_if.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural serial transmitter drives rxd and a
// negedge monitor logs delivered bytes and status pulses for per-scenario checks.
module tb_uart_rx;
    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 115_200;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int LAT    = 2 + CPB / 2 + 9 * CPB + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;

    uart_rx_if rx_if ();

    uart_rx #(.clk_hz(CLK_HZ), .baud_rate(BAUD)) dut (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .rx_if (rx_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Monitor log: one entry per byte newly presented on the handshake.
    int         rise_cyc[$];
    logic [7:0] rise_dat[$];
    int         vld_cycles = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         ov_at = 0;
    int         hold_bad = 0;
    logic       prev_vld = 1'b0;
    logic       prev_acc = 1'b0;
    logic [7:0] prev_dat = 8'h00;

    always @(negedge clk) begin
        if (rx_if.rx_valid && (!prev_vld || prev_acc)) begin
            rise_cyc.push_back(cyc);
            rise_dat.push_back(rx_if.rx_data);
        end
        if (rx_if.rx_valid) vld_cycles++;
        if (rx_if.frame_err) fe_cnt++;
        if (rx_if.overrun) begin
            ov_cnt++;
            ov_at = cyc;
        end
        if (rst && prev_vld && !prev_acc &&
            (!rx_if.rx_valid || rx_if.rx_data != prev_dat)) hold_bad++;
        prev_vld = rx_if.rx_valid;
        prev_acc = rx_if.rx_valid && rx_if.rx_ready;
        prev_dat = rx_if.rx_data;
    end

    task automatic clear_log();
        rise_cyc.delete();
        rise_dat.delete();
        vld_cycles = 0;
        fe_cnt     = 0;
        ov_cnt     = 0;
        hold_bad   = 0;
    endtask

    // Holds a line level for n cycles; always returns 1 time unit after a posedge.
    task automatic drive_bit(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int per,
                              output int t0);
        t0 = cyc;
        drive_bit(1'b0, per);
        for (int i = 0; i < 8; i++) drive_bit(b[i], per);
        drive_bit(stop_v, per);
    endtask

    task automatic expect_one(input string tag, input logic [7:0] want);
        checks++;
        if (rise_dat.size() !== 1) begin
            errors++;
            $display("FAIL %s_count got %0d want 1", tag, rise_dat.size());
        end else begin
            checks++;
            if (rise_dat[0] !== want) begin
                errors++;
                $display("FAIL %s_data got %h want %h", tag, rise_dat[0], want);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", rx_if.rx_valid); end
        checks++;
        if (rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", rx_if.rx_data); end
        checks++;
        if (rx_if.frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr got %b want 0", rx_if.frame_err); end
        checks++;
        if (rx_if.overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b want 0", rx_if.overrun); end
        checks++;
        if (rx_if.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", rx_if.busy); end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        drive_bit(1'b1, 20);
    endtask

    task automatic test_loopback();
        int t0;
        rx_if.rx_ready = 1'b1;
        clear_log();
        send_frame(8'h55, 1'b1, CPB, t0);
        drive_bit(1'b1, 20);
        expect_one("loop", 8'h55);
        if (rise_cyc.size() == 1) begin
            checks++;
            if (rise_cyc[0] - t0 < LAT - 1 || rise_cyc[0] - t0 > LAT + 1) begin
                errors++;
                $display("FAIL loop_latency got %0d want %0d+-1", rise_cyc[0] - t0, LAT);
            end
        end
        checks++;
        if (vld_cycles !== 1) begin errors++; $display("FAIL loop_vld_width got %0d want 1", vld_cycles); end
        checks++;
        if (fe_cnt !== 0 || ov_cnt !== 0) begin
            errors++;
            $display("FAIL loop_flags got fe=%0d ov=%0d want 0 0", fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int t0;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'hA5;
        rx_if.rx_ready = 1'b1;
        clear_log();
        for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, CPB, t0);
        drive_bit(1'b1, 20);
        checks++;
        if (rise_dat.size() !== 3) begin
            errors++;
            $display("FAIL b2b_count got %0d want 3", rise_dat.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rise_dat[i] !== bytes[i]) begin
                    errors++;
                    $display("FAIL b2b_data%0d got %h want %h", i, rise_dat[i], bytes[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (rise_cyc[i] - rise_cyc[i-1] < 10 * CPB - 2 || rise_cyc[i] - rise_cyc[i-1] > 10 * CPB + 2) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d got %0d want %0d+-2", i, rise_cyc[i] - rise_cyc[i-1], 10 * CPB);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int  t0;
        int  t_idle;
        bit  seen_idle;
        rx_if.rx_ready = 1'b1;
        clear_log();
        t0 = cyc;
        drive_bit(1'b0, 100);
        rxd = 1'b1;
        seen_idle = 1'b0;
        t_idle = 0;
        for (int i = 0; i < 400; i++) begin
            if (!rx_if.busy) begin
                seen_idle = 1'b1;
                t_idle = cyc - t0;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!seen_idle) begin
            errors++;
            $display("FAIL glitch_idle got busy=1 after 400 cycles want busy=0");
        end else begin
            checks++;
            if (t_idle < 218 || t_idle > 222) begin
                errors++;
                $display("FAIL glitch_idle_time got %0d want ~220", t_idle);
            end
        end
        drive_bit(1'b1, 20);
        checks++;
        if (rise_dat.size() !== 0) begin errors++; $display("FAIL glitch_valid got %0d bytes want 0", rise_dat.size()); end
        clear_log();
        send_frame(8'h3C, 1'b1, CPB, t0);
        drive_bit(1'b1, 20);
        expect_one("glitch_next", 8'h3C);
    endtask

    task automatic test_frame_err();
        int t0;
        rx_if.rx_ready = 1'b1;
        clear_log();
        send_frame(8'hC3, 1'b0, CPB, t0);
        drive_bit(1'b0, 2000);
        checks++;
        if (rx_if.busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_hold got %b want 1", rx_if.busy); end
        drive_bit(1'b1, 4);
        checks++;
        if (rx_if.busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release got %b want 0", rx_if.busy); end
        checks++;
        if (fe_cnt !== 1) begin errors++; $display("FAIL ferr_pulses got %0d want 1", fe_cnt); end
        checks++;
        if (rise_dat.size() !== 0) begin errors++; $display("FAIL ferr_valid got %0d bytes want 0", rise_dat.size()); end
        drive_bit(1'b1, 20);
        clear_log();
        send_frame(8'h81, 1'b1, CPB, t0);
        drive_bit(1'b1, 20);
        expect_one("ferr_next", 8'h81);
    endtask

    task automatic test_overrun();
        int t0a;
        int t0b;
        rx_if.rx_ready = 1'b0;
        clear_log();
        send_frame(8'hA5, 1'b1, CPB, t0a);
        send_frame(8'h3C, 1'b1, CPB, t0b);
        drive_bit(1'b1, 20);
        expect_one("ovr", 8'hA5);
        checks++;
        if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL ovr_held got v=%b d=%h want v=1 d=a5", rx_if.rx_valid, rx_if.rx_data);
        end
        checks++;
        if (hold_bad !== 0) begin errors++; $display("FAIL ovr_stable got %0d changes want 0", hold_bad); end
        checks++;
        if (ov_cnt !== 1) begin
            errors++;
            $display("FAIL ovr_pulses got %0d want 1", ov_cnt);
        end else begin
            checks++;
            if (ov_at - t0b < LAT - 1 || ov_at - t0b > LAT + 1) begin
                errors++;
                $display("FAIL ovr_time got %0d want %0d+-1", ov_at - t0b, LAT);
            end
        end
        rx_if.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept got v=%b want 0", rx_if.rx_valid); end
        drive_bit(1'b1, 5);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int t0;
        b = 8'h96;
        rx_if.rx_ready = 1'b1;
        clear_log();
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(b[i], CPB);
        drive_bit(b[4], 200);
        checks++;
        if (rx_if.busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre got %b want 1", rx_if.busy); end
        rst = 1'b0;
        #1;
        checks++;
        if (rx_if.busy !== 1'b0 || rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 8'h00 ||
            rx_if.frame_err !== 1'b0 || rx_if.overrun !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async got busy=%b v=%b d=%h fe=%b ov=%b want 0 0 00 0 0",
                     rx_if.busy, rx_if.rx_valid, rx_if.rx_data, rx_if.frame_err, rx_if.overrun);
        end
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        drive_bit(1'b1, 2 * CPB);
        checks++;
        if (rise_dat.size() !== 0 || fe_cnt !== 0 || ov_cnt !== 0) begin
            errors++;
            $display("FAIL rmid_pulses got bytes=%0d fe=%0d ov=%0d want 0 0 0", rise_dat.size(), fe_cnt, ov_cnt);
        end
        clear_log();
        send_frame(8'h5A, 1'b1, CPB, t0);
        drive_bit(1'b1, 20);
        expect_one("rmid_next", 8'h5A);
    endtask

    // Random bytes at up to +-1.8% baud error with random idle gaps.
    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int per;
        int t0;
        rx_if.rx_ready = 1'b1;
        clear_log();
        for (int i = 0; i < 3; i++) begin
            b   = 8'($urandom_range(0, 255));
            per = CPB - 8 + int'($urandom_range(0, 16));
            exp_q.push_back(b);
            send_frame(b, 1'b1, per, t0);
            drive_bit(1'b1, int'($urandom_range(0, 40)));
        end
        drive_bit(1'b1, 20);
        checks++;
        if (rise_dat.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got %0d want %0d", rise_dat.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rise_dat[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_data%0d got %h want %h", i, rise_dat[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (fe_cnt !== 0 || ov_cnt !== 0) begin
            errors++;
            $display("FAIL rand_flags got fe=%0d ov=%0d want 0 0", fe_cnt, ov_cnt);
        end
    endtask

    initial begin
        rx_if.rx_ready = 1'b0;
        #2;
        test_reset();
        test_loopback();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #950_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
